// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants for the instruction-fetch sequencing controller:
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - IFU next-PC select codes driven on nPC_sel
//   - default reset PC and exception vector
// -----------------------------------------------------------------------------
package fetch_pkg;

   // FSM state encodings
   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_MD_WAIT = 2'd1;
   localparam logic [1:0] S_EXC     = 2'd2;

   // IFU next-PC select
   localparam logic [1:0] NPC_SEQ = 2'b00;   // PC + 4
   localparam logic [1:0] NPC_BR  = 2'b01;   // branch, IFU applies cmp
   localparam logic [1:0] NPC_J   = 2'b10;   // j / jal
   localparam logic [1:0] NPC_REG = 2'b11;   // register / redirect target

   // Default addresses
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/md_busy_cnt.sv
// -----------------------------------------------------------------------------
// md_busy_cnt
// Reloadable saturating down-counter tracking how long the mult/div unit
// stays busy after an issue.
//   clk      in  : clock
//   reset    in  : asynchronous reset, active-low
//   load     in  : mult/div issued; (re)load LOAD_VAL, even when nonzero
//   busy     out : counter is nonzero
// -----------------------------------------------------------------------------
module md_busy_cnt #(
   parameter logic [3:0] LOAD_VAL = 4'd5
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic busy
);

   logic [3:0] cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= 4'd0;
      end else if (load) begin
         cnt_reg <= LOAD_VAL;
      end else if (cnt_reg != 4'd0) begin
         cnt_reg <= cnt_reg - 4'd1;
      end
   end

   assign busy = (cnt_reg != 4'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch sequencing controller for the five-stage MIPS pipeline. Chooses how
// the PC advances each cycle and drives IF/ID / ID/EX controls to match.
// Priority: exception > mult/div stall > load-use stall > eret > jr > jump >
// branch > sequential.
//
// Optional feature macro: FETCH_CTRL_EXC_EN
//   defined   : exception and eret redirect paths present, epc captured.
//   undefined : exc_req / is_eret ignored, EXC unreachable, epc = RESET_PC,
//               redir_sel / redir_pc tied to 0.
//
// Ports:
//   clk, reset (async, active-low)
//   ld_hazard, md_start, use_hilo, is_branch, is_jump, is_jr, is_eret : D/E info
//   exc_req, exc_pc           : M-stage exception request and its PC
//   nPC_sel[1:0]              : IFU next-PC select
//   redir_sel, redir_pc[31:0] : redirect override of the register-target mux
//   disable_PC, hold_D, clr_E, flush_D : pipeline controls
//   epc[31:0]                 : captured exception PC
// -----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = fetch_pkg::RESET_PC,
   parameter logic [31:0] EXC_VEC    = fetch_pkg::EXC_VEC,
   parameter int          MD_LATENCY = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_hazard,
   input  logic        md_start,
   input  logic        use_hilo,
   input  logic        is_branch,
   input  logic        is_jump,
   input  logic        is_jr,
   input  logic        is_eret,
   input  logic        exc_req,
   input  logic [31:0] exc_pc,
   output logic [1:0]  nPC_sel,
   output logic        redir_sel,
   output logic [31:0] redir_pc,
   output logic        disable_PC,
   output logic        hold_D,
   output logic        clr_E,
   output logic        flush_D,
   output logic [31:0] epc
);

   logic [1:0] state_reg;
   logic [1:0] state_next;
   logic       md_busy;
   logic       exc_fire;
   logic       eret_req;

   md_busy_cnt #(
      .LOAD_VAL (4'(MD_LATENCY))
   ) u_md_busy_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (md_start),
      .busy  (md_busy)
   );

`ifdef FETCH_CTRL_EXC_EN
   logic [31:0] epc_reg;

   // exc_req is masked during the single EXC cycle.
   assign exc_fire = exc_req && (state_reg != S_EXC);
   assign eret_req = is_eret;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         epc_reg <= RESET_PC;
      end else if (exc_fire) begin
         epc_reg <= exc_pc;
      end
   end

   assign epc = epc_reg;
`else
   logic unused_exc;

   assign exc_fire   = 1'b0;
   assign eret_req   = 1'b0;
   assign epc        = RESET_PC;
   assign unused_exc = ^{exc_req, is_eret, exc_pc, EXC_VEC};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Outputs are combinational; while reset is low they sit at their reset
   // values regardless of what the D-stage inputs say.
   always_comb begin
      state_next = S_RUN;
      nPC_sel    = NPC_SEQ;
      redir_sel  = 1'b0;
      redir_pc   = 32'd0;
      disable_PC = 1'b0;
      hold_D     = 1'b0;
      clr_E      = 1'b0;
      flush_D    = 1'b0;
      if (reset) begin
         case (state_reg)
            S_EXC: begin
               // Handler fetch is in flight; kill whatever sits in IF/ID.
               flush_D    = 1'b1;
               state_next = S_RUN;
            end
            default: begin
               // RUN and MD_WAIT share the decision chain. In MD_WAIT the
               // stall holds regardless of use_hilo until the counter drains;
               // on the drain cycle the held instruction proceeds normally.
               state_next = S_RUN;
               if (exc_fire) begin
                  // Exception overrides any stall in progress.
                  nPC_sel    = NPC_REG;
                  redir_sel  = 1'b1;
                  redir_pc   = EXC_VEC;
                  flush_D    = 1'b1;
                  clr_E      = 1'b1;
                  state_next = S_EXC;
               end else if (md_busy && (use_hilo || state_reg == S_MD_WAIT)) begin
                  disable_PC = 1'b1;
                  hold_D     = 1'b1;
                  clr_E      = 1'b1;
                  state_next = S_MD_WAIT;
               end else if (ld_hazard) begin
                  disable_PC = 1'b1;
                  hold_D     = 1'b1;
                  clr_E      = 1'b1;
               end else if (eret_req) begin
                  // eret has no delay slot, so the fetched successor is dropped.
                  nPC_sel   = NPC_REG;
                  redir_sel = 1'b1;
                  redir_pc  = epc;
                  flush_D   = 1'b1;
               end else if (is_jr) begin
                  nPC_sel = NPC_REG;
               end else if (is_jump) begin
                  nPC_sel = NPC_J;
               end else if (is_branch) begin
                  nPC_sel = NPC_BR;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed-vector bench for fetch_ctrl. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled a few units later, well clear of
// the next edge. Exception/eret vectors are built only when
// FETCH_CTRL_EXC_EN is defined; otherwise the disabled-path vector runs.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        ld_hazard, md_start, use_hilo;
   logic        is_branch, is_jump, is_jr, is_eret;
   logic        exc_req;
   logic [31:0] exc_pc;
   logic [1:0]  nPC_sel;
   logic        redir_sel;
   logic [31:0] redir_pc;
   logic        disable_PC, hold_D, clr_E, flush_D;
   logic [31:0] epc;

   int n_chk  = 0;
   int n_pass = 0;

   fetch_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .ld_hazard  (ld_hazard),
      .md_start   (md_start),
      .use_hilo   (use_hilo),
      .is_branch  (is_branch),
      .is_jump    (is_jump),
      .is_jr      (is_jr),
      .is_eret    (is_eret),
      .exc_req    (exc_req),
      .exc_pc     (exc_pc),
      .nPC_sel    (nPC_sel),
      .redir_sel  (redir_sel),
      .redir_pc   (redir_pc),
      .disable_PC (disable_PC),
      .hold_D     (hold_D),
      .clr_E      (clr_E),
      .flush_D    (flush_D),
      .epc        (epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %-16s = %08h", tag, got);
      end else begin
         $display("FAIL %-16s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      ld_hazard = 1'b0;
      md_start  = 1'b0;
      use_hilo  = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
      is_jr     = 1'b0;
      is_eret   = 1'b0;
      exc_req   = 1'b0;
      exc_pc    = 32'd0;
   endtask

   // Advance to just after the next rising edge and clear all inputs.
   task automatic cyc();
      @(posedge clk);
      #1;
      clr_in();
   endtask

   initial begin
      #20000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- reset with ld_hazard asserted ----------------
      clr_in();
      reset     = 1'b0;
      ld_hazard = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("rst nPC_sel",    {30'd0, nPC_sel}, 32'd0);
      check("rst disable_PC", {31'd0, disable_PC}, 32'd0);
      check("rst hold_D",     {31'd0, hold_D}, 32'd0);
      check("rst clr_E",      {31'd0, clr_E}, 32'd0);
      check("rst flush_D",    {31'd0, flush_D}, 32'd0);
      check("rst redir_sel",  {31'd0, redir_sel}, 32'd0);
      check("rst redir_pc",   redir_pc, 32'd0);
      check("rst epc",        epc, 32'h0000_3000);

      // release reset; the first post-reset cycle sees the load-use stall
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("post-rst dis_PC", {31'd0, disable_PC}, 32'd1);
      check("post-rst epc",    epc, 32'h0000_3000);

      // ---------------- load-use with branch ----------------
      cyc(); ld_hazard = 1'b1; is_branch = 1'b1; #1;
      check("lu disable_PC", {31'd0, disable_PC}, 32'd1);
      check("lu hold_D",     {31'd0, hold_D}, 32'd1);
      check("lu clr_E",      {31'd0, clr_E}, 32'd1);
      check("lu nPC_sel",    {30'd0, nPC_sel}, 32'd0);
      cyc(); is_branch = 1'b1; #1;
      check("lu+1 nPC_sel",  {30'd0, nPC_sel}, 32'd1);
      check("lu+1 dis_PC",   {31'd0, disable_PC}, 32'd0);

      // ---------------- control transfers ----------------
      cyc(); is_jump = 1'b1; #1;
      check("jump nPC_sel", {30'd0, nPC_sel}, 32'd2);
      cyc(); is_jr = 1'b1; is_jump = 1'b1; is_branch = 1'b1; #1;
      check("jr prio nPC",  {30'd0, nPC_sel}, 32'd3);
      check("jr redir_sel", {31'd0, redir_sel}, 32'd0);
      check("jr flush_D",   {31'd0, flush_D}, 32'd0);
      cyc(); #1;
      check("seq nPC_sel",  {30'd0, nPC_sel}, 32'd0);

      // ---------------- mult/div stall, latency 5 ----------------
      cyc(); md_start = 1'b1; #1;
      check("md c0 dis_PC", {31'd0, disable_PC}, 32'd0);
      cyc(); use_hilo = 1'b1; is_jump = 1'b1; #1;
      check("md c1 dis_PC", {31'd0, disable_PC}, 32'd1);
      check("md c1 nPC",    {30'd0, nPC_sel}, 32'd0);
      for (int c = 2; c <= 5; c++) begin
         cyc(); use_hilo = 1'b1; #1;
         check($sformatf("md c%0d dis_PC", c), {31'd0, disable_PC}, 32'd1);
      end
      cyc(); use_hilo = 1'b1; #1;
      check("md c6 dis_PC", {31'd0, disable_PC}, 32'd0);
      check("md c6 nPC",    {30'd0, nPC_sel}, 32'd0);
      check("md c6 clr_E",  {31'd0, clr_E}, 32'd0);

      // ---------------- reload during MD_WAIT extends stall ----------------
      cyc(); md_start = 1'b1; #1;
      cyc(); use_hilo = 1'b1; #1;
      cyc(); use_hilo = 1'b1; #1;
      cyc(); use_hilo = 1'b1; md_start = 1'b1; #1;
      check("rl c3 dis_PC", {31'd0, disable_PC}, 32'd1);
      for (int c = 4; c <= 8; c++) begin
         cyc(); use_hilo = 1'b1; #1;
      end
      check("rl c8 dis_PC", {31'd0, disable_PC}, 32'd1);
      cyc(); use_hilo = 1'b1; #1;
      check("rl c9 dis_PC", {31'd0, disable_PC}, 32'd0);

      // ---------------- async reset mid-stall ----------------
      cyc(); md_start = 1'b1; #1;
      cyc(); use_hilo = 1'b1; #1;
      check("ar stall",     {31'd0, disable_PC}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("ar in rst",    {31'd0, disable_PC}, 32'd0);
      #1 reset = 1'b1;
      #1;
      check("ar released",  {31'd0, disable_PC}, 32'd0);
      cyc(); use_hilo = 1'b1; #1;
      check("ar next cyc",  {31'd0, disable_PC}, 32'd0);

`ifdef FETCH_CTRL_EXC_EN
      // ---------------- exception during MD_WAIT ----------------
      cyc(); md_start = 1'b1; #1;
      cyc(); use_hilo = 1'b1; #1;
      cyc(); use_hilo = 1'b1; exc_req = 1'b1; exc_pc = 32'h0000_3010; #1;
      check("exc redir_pc",  redir_pc, 32'h0000_4180);
      check("exc redir_sel", {31'd0, redir_sel}, 32'd1);
      check("exc nPC_sel",   {30'd0, nPC_sel}, 32'd3);
      check("exc flush_D",   {31'd0, flush_D}, 32'd1);
      check("exc clr_E",     {31'd0, clr_E}, 32'd1);
      check("exc epc pre",   epc, 32'h0000_3000);
      // EXC cycle: a second request is masked
      cyc(); exc_req = 1'b1; exc_pc = 32'h0000_3020; #1;
      check("EXC epc",       epc, 32'h0000_3010);
      check("EXC flush_D",   {31'd0, flush_D}, 32'd1);
      check("EXC nPC_sel",   {30'd0, nPC_sel}, 32'd0);
      check("EXC redir_sel", {31'd0, redir_sel}, 32'd0);
      cyc(); #1;
      check("exc+2 flush_D", {31'd0, flush_D}, 32'd0);
      check("exc+2 epc",     epc, 32'h0000_3010);

      // ---------------- eret ----------------
      cyc(); is_eret = 1'b1; ld_hazard = 1'b1; #1;
      check("eret lu nPC",   {30'd0, nPC_sel}, 32'd0);
      check("eret lu dis",   {31'd0, disable_PC}, 32'd1);
      cyc(); is_eret = 1'b1; is_jump = 1'b1; #1;
      check("eret nPC_sel",  {30'd0, nPC_sel}, 32'd3);
      check("eret redir_sel",{31'd0, redir_sel}, 32'd1);
      check("eret redir_pc", redir_pc, 32'h0000_3010);
      check("eret flush_D",  {31'd0, flush_D}, 32'd1);
`else
      // ---------------- exception path absent ----------------
      cyc(); exc_req = 1'b1; exc_pc = 32'h0000_3010; is_jump = 1'b1; #1;
      check("noexc nPC_sel", {30'd0, nPC_sel}, 32'd2);
      check("noexc redir",   {31'd0, redir_sel}, 32'd0);
      check("noexc rpc",     redir_pc, 32'd0);
      check("noexc flush_D", {31'd0, flush_D}, 32'd0);
      cyc(); is_eret = 1'b1; #1;
      check("noexc epc",     epc, 32'h0000_3000);
      check("noeret nPC",    {30'd0, nPC_sel}, 32'd0);
      check("noeret flush",  {31'd0, flush_D}, 32'd0);
`endif

      cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
